// File: rtl/alu_result_fifo.sv
// alu_result_fifo
//
// Result buffer behind the 8-bit datapath ALU. Each accepted ALU result is
// stored with its zero flag and opcode tag. Entries go to the consumer over a
// valid/ready handshake, so consumer back-pressure never reaches the ALU.
//
// Optional statistics are built when ALU_RESULT_FIFO_STATS_EN is defined.
//
// Parameters:
//   DEPTH   number of entries (power of two, >= 2)
//   DATA_W  result width
//   OP_W    opcode tag width
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst          asynchronous active-high reset
//   flush        synchronous clear of contents (and stats); beats push/pop
//   in_valid     producer offers a result
//   in_ready     room for one more entry (depends on occupancy only)
//   in_result    ALU result
//   in_zero      ALU zero flag, stored as given
//   in_opcode    opcode tag
//   out_valid    head entry present
//   out_ready    consumer takes the head entry
//   out_result   head result (0 when empty)
//   out_zero     head zero flag (0 when empty)
//   out_opcode   head opcode (0 when empty)
//   count        current occupancy
//   acc_sum      [stats] sum of accepted results, mod 2^16
//   zero_cnt     [stats] accepted results flagged zero, saturating at 255
module alu_result_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OP_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_result,
  input  logic                     in_zero,
  input  logic [OP_W-1:0]          in_opcode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_result,
  output logic                     out_zero,
  output logic [OP_W-1:0]          out_opcode,
`ifdef ALU_RESULT_FIFO_STATS_EN
  output logic [15:0]              acc_sum,
  output logic [7:0]               zero_cnt,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CntFull = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);

  // Elaboration-time guard on the depth parameter.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("alu_result_fifo: DEPTH must be a power of two >= 2");
  end

  // Storage (not reset; outputs are masked while empty instead).
  logic [DATA_W-1:0] r_mem_result [DEPTH];
  logic              r_mem_zero   [DEPTH];
  logic [OP_W-1:0]   r_mem_opcode [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  // Handshake status comes from occupancy only, so in_ready never depends on
  // out_ready and a full FIFO refuses a push even when it pops that cycle.
  assign w_in_ready  = (r_count != CntFull);
  assign w_out_valid = (r_count != '0);
  assign w_push      = in_valid & w_in_ready;
  assign w_pop       = w_out_valid & out_ready;

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign count     = r_count;

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntOne;
        2'b01:   r_count <= r_count - CntOne;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry write. Flush suppresses the write so the slot stays untouched.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem_result[r_wr_ptr] <= in_result;
      r_mem_zero[r_wr_ptr]   <= in_zero;
      r_mem_opcode[r_wr_ptr] <= in_opcode;
    end
  end

  // Head read is combinational; forced to zero while empty so stale storage
  // never leaks onto the consumer bus.
  always_comb begin
    out_result = '0;
    out_zero   = 1'b0;
    out_opcode = '0;
    if (w_out_valid) begin
      out_result = r_mem_result[r_rd_ptr];
      out_zero   = r_mem_zero[r_rd_ptr];
      out_opcode = r_mem_opcode[r_rd_ptr];
    end
  end

`ifdef ALU_RESULT_FIFO_STATS_EN
  logic [15:0] r_acc_sum;
  logic [7:0]  r_zero_cnt;
  logic [15:0] w_result_ext;

  assign w_result_ext = 16'(in_result);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_sum  <= '0;
      r_zero_cnt <= '0;
    end else if (flush) begin
      r_acc_sum  <= '0;
      r_zero_cnt <= '0;
    end else if (w_push) begin
      r_acc_sum <= r_acc_sum + w_result_ext;
      if (in_zero && (r_zero_cnt != 8'hFF)) begin
        r_zero_cnt <= r_zero_cnt + 8'd1;
      end
    end
  end

  assign acc_sum  = r_acc_sum;
  assign zero_cnt = r_zero_cnt;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed self-checking bench for alu_result_fifo (DEPTH=4, DATA_W=8, OP_W=4).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_alu_result_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_result = 8'h00;
  logic       in_zero = 1'b0;
  logic [3:0] in_opcode = 4'h0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_result;
  logic       out_zero;
  logic [3:0] out_opcode;
  logic [2:0] count;
`ifdef ALU_RESULT_FIFO_STATS_EN
  logic [15:0] acc_sum;
  logic [7:0]  zero_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_result_fifo #(
    .DEPTH (4),
    .DATA_W(8),
    .OP_W  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_zero   (in_zero),
    .in_opcode (in_opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_zero  (out_zero),
    .out_opcode(out_opcode),
`ifdef ALU_RESULT_FIFO_STATS_EN
    .acc_sum   (acc_sum),
    .zero_cnt  (zero_cnt),
`endif
    .count     (count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if ({out_result, out_zero, out_opcode} !== 13'h0) begin
      errors++; $display("FAIL reset_head: got %h/%b/%h want 0/0/0", out_result, out_zero, out_opcode);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_push();
    in_valid = 1'b1; in_result = 8'h3C; in_zero = 1'b0; in_opcode = 4'h0; out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL no_bypass: got out_valid=%b want 0", out_valid); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
    checks++; if (out_result !== 8'h3C) begin errors++; $display("FAIL single_result: got %h want 3c", out_result); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_drain: got %0d want 0", count); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_result = 8'(i); in_zero = (i == 2); in_opcode = 4'(i + 8);
      step();
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    in_result = 8'h05; in_zero = 1'b0; in_opcode = 4'h5;
    step();
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL overflow_count: got %0d want 4", count); end
    checks++; if (out_result !== 8'h01) begin errors++; $display("FAIL overflow_head: got %h want 01", out_result); end
    // Head must hold while stalled.
    step();
    checks++; if (out_result !== 8'h01 || out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_hold: got %h/%b want 01/1", out_result, out_valid);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if ({out_result, out_zero, out_opcode} !== {8'(i), (i == 2), 4'(i + 8)}) begin
        errors++;
        $display("FAIL drain_entry%0d: got %h/%b/%h want %h/%b/%h", i, out_result, out_zero,
                 out_opcode, 8'(i), (i == 2), 4'(i + 8));
      end
      step();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_result !== 8'h00) begin
      errors++; $display("FAIL drain_empty: got %b/%h want 0/00", out_valid, out_result);
    end
    // Pop request while empty must not underflow.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL empty_pop: got %0d want 0", count); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_result = 8'(8'h11 + i); in_zero = 1'b0; in_opcode = 4'h1;
      step();
    end
    in_result = 8'h55; out_ready = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fullpp_ready_before: got %b want 0", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fullpp_count: got %0d want 3", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fullpp_ready_after: got %b want 1", in_ready); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (out_result !== 8'(8'h11 + i)) begin
        errors++; $display("FAIL fullpp_drain%0d: got %h want %h", i, out_result, 8'(8'h11 + i));
      end
      step();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fullpp_no_55: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_result = 8'h80; in_zero = 1'b0; in_opcode = 4'h7;
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_result = 8'(8'h81 + i);
      checks++; if (out_result !== 8'(8'h80 + i) || count !== 3'd1) begin
        errors++;
        $display("FAIL stream%0d: got %h cnt %0d want %h cnt 1", i, out_result, count, 8'(8'h80 + i));
      end
      step();
    end
    in_valid = 1'b0;
    checks++; if (out_result !== 8'h8A) begin errors++; $display("FAIL stream_last: got %h want 8a", out_result); end
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_zero = 1'b0; in_opcode = 4'h2;
    in_result = 8'hA1; step();
    in_result = 8'hA2; step();
    flush = 1'b1; in_result = 8'hAA; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_clear: got cnt %0d valid %b want 0/0", count, out_valid);
    end
    step();
    checks++; if (out_valid !== 1'b0 || out_result !== 8'h00) begin
      errors++; $display("FAIL flush_no_aa: got %b/%h want 0/00", out_valid, out_result);
    end
    in_valid = 1'b1; in_result = 8'h5A; in_zero = 1'b1; in_opcode = 4'hE;
    step();
    in_valid = 1'b0;
    checks++; if ({out_result, out_zero, out_opcode} !== {8'h5A, 1'b1, 4'hE} || count !== 3'd1) begin
      errors++; $display("FAIL flush_resume: got %h/%b/%h cnt %0d want 5a/1/e cnt 1", out_result,
                         out_zero, out_opcode, count);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    in_valid = 1'b1; in_result = 8'h42; in_zero = 1'b0; in_opcode = 4'h3;
    step(); step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset: got cnt %0d valid %b ready %b want 0/0/1", count, out_valid,
                         in_ready);
    end
    step();
    rst = 1'b0;
    in_valid = 1'b1; in_result = 8'h24;
    step();
    in_valid = 1'b0;
    checks++; if (count !== 3'd1 || out_result !== 8'h24) begin
      errors++; $display("FAIL reset_resume: got cnt %0d head %h want 1/24", count, out_result);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

`ifdef ALU_RESULT_FIFO_STATS_EN
  task automatic test_stats();
    flush = 1'b1; step(); flush = 1'b0;
    checks++; if (acc_sum !== 16'h0 || zero_cnt !== 8'h0) begin
      errors++; $display("FAIL stats_flush: got %h/%0d want 0000/0", acc_sum, zero_cnt);
    end
    in_valid = 1'b1; in_opcode = 4'h0;
    in_result = 8'h00; in_zero = 1'b1; step();
    in_result = 8'hFF; in_zero = 1'b0; step();
    in_result = 8'h02; in_zero = 1'b0; step();
    in_valid = 1'b0;
    checks++; if (acc_sum !== 16'h0101 || zero_cnt !== 8'd1) begin
      errors++; $display("FAIL stats_sum: got %h/%0d want 0101/1", acc_sum, zero_cnt);
    end
    in_valid = 1'b1; in_result = 8'h00; in_zero = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 300; i++) step();
    in_valid = 1'b0;
    checks++; if (zero_cnt !== 8'd255 || acc_sum !== 16'h0101) begin
      errors++; $display("FAIL stats_sat: got %h/%0d want 0101/255", acc_sum, zero_cnt);
    end
    flush = 1'b1; in_valid = 1'b1; in_result = 8'h10; step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (acc_sum !== 16'h0 || zero_cnt !== 8'h0) begin
      errors++; $display("FAIL stats_flush_wins: got %h/%0d want 0000/0", acc_sum, zero_cnt);
    end
  endtask
`endif

  initial begin
    #2;
    test_reset();
    test_single_push();
    test_fill_drain();
    test_full_push_pop();
    test_back_to_back();
    test_flush();
    test_mid_reset();
`ifdef ALU_RESULT_FIFO_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
